// File: rtl/axi_arb_pkg.sv
// Shared definitions for the AXI bus arbiter: FSM states, owner IDs and
// the fixed AXI attribute values driven on every transaction.
package axi_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR,
    WR_RESP
  } arb_state_e;

  // Owner codes double as the AXI transaction ID and as grant-vector bit indices
  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  localparam logic [1:0] BURST_INCR    = 2'b01;
  localparam logic [3:0] CACHE_DEFAULT = 4'b0010;

endpackage

// File: rtl/axi_arb_rr.sv
// Two-way grant selector for the ibus/dbus requesters. Defining AXI_ARB_RR_EN
// selects round-robin; otherwise dbus has fixed priority.
module axi_arb_rr
  import axi_arb_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

`ifdef AXI_ARB_RR_EN
  logic last_q;

  // On a tie the requester that did not win last time gets the grant
  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = (last_q == OWNER_D) ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_q <= OWNER_D;
    end else if (|req_i) begin
      last_q <= gnt_o[OWNER_D];
    end
  end
`else
  logic unused_clk_rst;

  always_comb begin
    gnt_o = req_i[OWNER_D] ? 2'b10 : req_i;
  end

  assign unused_clk_rst = clock ^ reset;
`endif

endmodule

// File: rtl/axi_bus_arbiter.sv
// Shares one AXI4 master port between ibus (reads) and dbus (reads/writes),
// one transaction at a time. Define AXI_ARB_RR_EN for round-robin arbitration.
module axi_bus_arbiter
  import axi_arb_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_USER_WIDTH = 1
)(
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        i_req_valid,
  output logic                        i_req_ready,
  input  logic [AXI_ADDR_WIDTH-1:0]   i_req_addr,
  input  logic [7:0]                  i_req_len,
  input  logic [2:0]                  i_req_size,
  output logic                        i_r_valid,
  output logic                        i_r_last,
  output logic [AXI_DATA_WIDTH-1:0]   i_r_data,
  output logic [1:0]                  i_r_resp,
  input  logic                        d_req_valid,
  output logic                        d_req_ready,
  input  logic                        d_req_write,
  input  logic [AXI_ADDR_WIDTH-1:0]   d_req_addr,
  input  logic [7:0]                  d_req_len,
  input  logic [2:0]                  d_req_size,
  input  logic                        d_w_valid,
  output logic                        d_w_ready,
  input  logic [AXI_DATA_WIDTH-1:0]   d_w_data,
  input  logic [AXI_DATA_WIDTH/8-1:0] d_w_strb,
  output logic                        d_r_valid,
  output logic                        d_r_last,
  output logic [AXI_DATA_WIDTH-1:0]   d_r_data,
  output logic [1:0]                  d_r_resp,
  output logic                        d_b_valid,
  output logic [1:0]                  d_b_resp,
  input  logic                        awready,
  output logic                        awvalid,
  output logic [AXI_ADDR_WIDTH-1:0]   awaddr,
  output logic [2:0]                  awprot,
  output logic [AXI_ID_WIDTH-1:0]     awid,
  output logic [AXI_USER_WIDTH-1:0]   awuser,
  output logic [7:0]                  awlen,
  output logic [2:0]                  awsize,
  output logic [1:0]                  awburst,
  output logic                        awlock,
  output logic [3:0]                  awcache,
  output logic [3:0]                  awqos,
  output logic [3:0]                  awregion,
  input  logic                        wready,
  output logic                        wvalid,
  output logic [AXI_DATA_WIDTH-1:0]   wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] wstrb,
  output logic                        wlast,
  output logic [AXI_USER_WIDTH-1:0]   wuser,
  output logic                        bready,
  input  logic                        bvalid,
  input  logic [1:0]                  bresp,
  input  logic [AXI_ID_WIDTH-1:0]     bid,
  input  logic [AXI_USER_WIDTH-1:0]   buser,
  input  logic                        arready,
  output logic                        arvalid,
  output logic [AXI_ADDR_WIDTH-1:0]   araddr,
  output logic [2:0]                  arprot,
  output logic [AXI_ID_WIDTH-1:0]     arid,
  output logic [AXI_USER_WIDTH-1:0]   aruser,
  output logic [7:0]                  arlen,
  output logic [2:0]                  arsize,
  output logic [1:0]                  arburst,
  output logic                        arlock,
  output logic [3:0]                  arcache,
  output logic [3:0]                  arqos,
  output logic [3:0]                  arregion,
  output logic                        rready,
  input  logic                        rvalid,
  input  logic [1:0]                  rresp,
  input  logic [AXI_DATA_WIDTH-1:0]   rdata,
  input  logic                        rlast,
  input  logic [AXI_ID_WIDTH-1:0]     rid,
  input  logic [AXI_USER_WIDTH-1:0]   ruser
);

  arb_state_e                state_q;
  logic                      owner_q;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [7:0]                len_q;
  logic [2:0]                size_q;
  logic                      arvalid_q, awvalid_q, rready_q, bready_q;
  logic                      aw_done_q, w_done_q, wlast_q;
  logic [7:0]                w_cnt_q;

  logic                      idle;
  logic [1:0]                req, gnt;
  logic [AXI_ADDR_WIDTH-1:0] sel_addr;
  logic [7:0]                sel_len;
  logic [2:0]                sel_size;
  logic                      sel_write;
  logic                      w_fire, aw_done_now, w_done_now;
  logic                      r_hit, b_hit;
  logic [AXI_ID_WIDTH-1:0]   owner_id;
  logic                      unused_inputs;

  // Requests are only offered to the selector while idle and out of reset
  assign idle = (state_q == IDLE) && !reset;
  assign req  = {d_req_valid, i_req_valid} & {2{idle}};

  axi_arb_rr u_rr (
    .clock (clock),
    .reset (reset),
    .req_i (req),
    .gnt_o (gnt)
  );

  assign i_req_ready = gnt[OWNER_I];
  assign d_req_ready = gnt[OWNER_D];

  assign sel_addr  = gnt[OWNER_D] ? d_req_addr : i_req_addr;
  assign sel_len   = gnt[OWNER_D] ? d_req_len  : i_req_len;
  assign sel_size  = gnt[OWNER_D] ? d_req_size : i_req_size;
  assign sel_write = gnt[OWNER_D] & d_req_write;

  assign wvalid      = (state_q == WR) && !w_done_q && d_w_valid;
  assign d_w_ready   = (state_q == WR) && !w_done_q && wready;
  assign w_fire      = wvalid && wready;
  assign aw_done_now = aw_done_q || (awvalid_q && awready);
  assign w_done_now  = w_done_q || (w_fire && wlast_q);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= OWNER_I;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      arvalid_q <= 1'b0;
      awvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      bready_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      wlast_q   <= 1'b0;
      w_cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|gnt) begin
            owner_q   <= gnt[OWNER_D];
            addr_q    <= sel_addr;
            len_q     <= sel_len;
            size_q    <= sel_size;
            w_cnt_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            if (sel_write) begin
              state_q   <= WR;
              awvalid_q <= 1'b1;
              wlast_q   <= (sel_len == 8'd0);
            end else begin
              state_q   <= RD_ADDR;
              arvalid_q <= 1'b1;
            end
          end
        end
        RD_ADDR: begin
          if (arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (rvalid && rlast) begin
            rready_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        WR: begin
          if (awvalid_q && awready) begin
            awvalid_q <= 1'b0;
            aw_done_q <= 1'b1;
          end
          // wlast is precomputed one beat ahead so it leaves a flop
          if (w_fire) begin
            w_cnt_q <= w_cnt_q + 8'd1;
            if (wlast_q) begin
              wlast_q  <= 1'b0;
              w_done_q <= 1'b1;
            end else begin
              wlast_q <= ((w_cnt_q + 8'd1) == len_q);
            end
          end
          if (aw_done_now && w_done_now) begin
            bready_q <= 1'b1;
            state_q  <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (bvalid) begin
            bready_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign r_hit = (state_q == RD_DATA) && rvalid;
  assign b_hit = (state_q == WR_RESP) && bvalid;

  assign i_r_valid = r_hit && (owner_q == OWNER_I);
  assign i_r_last  = i_r_valid && rlast;
  assign i_r_data  = i_r_valid ? rdata : '0;
  assign i_r_resp  = i_r_valid ? rresp : 2'b00;
  assign d_r_valid = r_hit && (owner_q == OWNER_D);
  assign d_r_last  = d_r_valid && rlast;
  assign d_r_data  = d_r_valid ? rdata : '0;
  assign d_r_resp  = d_r_valid ? rresp : 2'b00;
  assign d_b_valid = b_hit;
  assign d_b_resp  = b_hit ? bresp : 2'b00;

  assign owner_id = {{(AXI_ID_WIDTH-1){1'b0}}, owner_q};

  // Constant attributes are qualified by valid so every output idles at 0
  assign arvalid  = arvalid_q;
  assign araddr   = addr_q;
  assign arid     = owner_id;
  assign arlen    = len_q;
  assign arsize   = size_q;
  assign arburst  = arvalid_q ? BURST_INCR : 2'b00;
  assign arcache  = arvalid_q ? CACHE_DEFAULT : 4'b0000;
  assign arprot   = '0;
  assign arlock   = 1'b0;
  assign arqos    = '0;
  assign arregion = '0;
  assign aruser   = '0;

  assign awvalid  = awvalid_q;
  assign awaddr   = addr_q;
  assign awid     = owner_id;
  assign awlen    = len_q;
  assign awsize   = size_q;
  assign awburst  = awvalid_q ? BURST_INCR : 2'b00;
  assign awcache  = awvalid_q ? CACHE_DEFAULT : 4'b0000;
  assign awprot   = '0;
  assign awlock   = 1'b0;
  assign awqos    = '0;
  assign awregion = '0;
  assign awuser   = '0;

  assign wdata = wvalid ? d_w_data : '0;
  assign wstrb = wvalid ? d_w_strb : '0;
  assign wlast = wlast_q;
  assign wuser = '0;

  assign rready = rready_q;
  assign bready = bready_q;

  assign unused_inputs = ^{rid, ruser, bid, buser};

endmodule

// File: tb/tb_axi_bus_arbiter.sv
// Directed bench for axi_bus_arbiter: table-driven read bursts plus hand-written
// write, reset and arbitration sequences (arbitration expectations follow AXI_ARB_RR_EN).
module tb_axi_bus_arbiter;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int IW = 4;
  localparam int UW = 1;

  logic          clock = 1'b0;
  logic          reset;
  logic          i_req_valid, i_req_ready;
  logic [AW-1:0] i_req_addr;
  logic [7:0]    i_req_len;
  logic [2:0]    i_req_size;
  logic          i_r_valid, i_r_last;
  logic [DW-1:0] i_r_data;
  logic [1:0]    i_r_resp;
  logic          d_req_valid, d_req_ready, d_req_write;
  logic [AW-1:0] d_req_addr;
  logic [7:0]    d_req_len;
  logic [2:0]    d_req_size;
  logic          d_w_valid, d_w_ready;
  logic [DW-1:0] d_w_data;
  logic [DW/8-1:0] d_w_strb;
  logic          d_r_valid, d_r_last;
  logic [DW-1:0] d_r_data;
  logic [1:0]    d_r_resp;
  logic          d_b_valid;
  logic [1:0]    d_b_resp;
  logic          awready, awvalid, awlock;
  logic [AW-1:0] awaddr;
  logic [2:0]    awprot, awsize;
  logic [IW-1:0] awid;
  logic [UW-1:0] awuser;
  logic [7:0]    awlen;
  logic [1:0]    awburst;
  logic [3:0]    awcache, awqos, awregion;
  logic          wready, wvalid, wlast;
  logic [DW-1:0] wdata;
  logic [DW/8-1:0] wstrb;
  logic [UW-1:0] wuser;
  logic          bready, bvalid;
  logic [1:0]    bresp;
  logic [IW-1:0] bid;
  logic [UW-1:0] buser;
  logic          arready, arvalid, arlock;
  logic [AW-1:0] araddr;
  logic [2:0]    arprot, arsize;
  logic [IW-1:0] arid;
  logic [UW-1:0] aruser;
  logic [7:0]    arlen;
  logic [1:0]    arburst;
  logic [3:0]    arcache, arqos, arregion;
  logic          rready, rvalid, rlast;
  logic [1:0]    rresp;
  logic [DW-1:0] rdata;
  logic [IW-1:0] rid;
  logic [UW-1:0] ruser;

  int nCompared   = 0;
  int nMismatched = 0;

  always #5 clock = ~clock;

  axi_bus_arbiter #(
    .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW), .AXI_USER_WIDTH(UW)
  ) dut (
    .clock(clock), .reset(reset),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_req_len(i_req_len), .i_req_size(i_req_size),
    .i_r_valid(i_r_valid), .i_r_last(i_r_last), .i_r_data(i_r_data), .i_r_resp(i_r_resp),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_write(d_req_write),
    .d_req_addr(d_req_addr), .d_req_len(d_req_len), .d_req_size(d_req_size),
    .d_w_valid(d_w_valid), .d_w_ready(d_w_ready), .d_w_data(d_w_data), .d_w_strb(d_w_strb),
    .d_r_valid(d_r_valid), .d_r_last(d_r_last), .d_r_data(d_r_data), .d_r_resp(d_r_resp),
    .d_b_valid(d_b_valid), .d_b_resp(d_b_resp),
    .awready(awready), .awvalid(awvalid), .awaddr(awaddr), .awprot(awprot), .awid(awid),
    .awuser(awuser), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awlock(awlock),
    .awcache(awcache), .awqos(awqos), .awregion(awregion),
    .wready(wready), .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wuser(wuser),
    .bready(bready), .bvalid(bvalid), .bresp(bresp), .bid(bid), .buser(buser),
    .arready(arready), .arvalid(arvalid), .araddr(araddr), .arprot(arprot), .arid(arid),
    .aruser(aruser), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arlock(arlock),
    .arcache(arcache), .arqos(arqos), .arregion(arregion),
    .rready(rready), .rvalid(rvalid), .rresp(rresp), .rdata(rdata), .rlast(rlast),
    .rid(rid), .ruser(ruser)
  );

  typedef struct {
    logic          owner;
    logic [AW-1:0] addr;
    logic [7:0]    len;
    logic [2:0]    size;
    logic [1:0]    rresp;
    logic [IW-1:0] expArid;
    logic [1:0]    expResp;
  } rdVec_t;

  rdVec_t vecs[4];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clearInputs();
    i_req_valid = 0; i_req_addr = '0; i_req_len = '0; i_req_size = '0;
    d_req_valid = 0; d_req_write = 0; d_req_addr = '0; d_req_len = '0; d_req_size = '0;
    d_w_valid = 0; d_w_data = '0; d_w_strb = '0;
    awready = 0; wready = 0; bvalid = 0; bresp = '0; bid = '0; buser = '0;
    arready = 0; rvalid = 0; rresp = '0; rdata = '0; rlast = 0; rid = '0; ruser = '0;
  endtask

  task automatic applyStimulus(input logic owner, input logic [AW-1:0] addr,
                               input logic [7:0] len, input logic [2:0] size);
    if (owner) begin
      d_req_valid = 1; d_req_write = 0; d_req_addr = addr; d_req_len = len; d_req_size = size;
    end else begin
      i_req_valid = 1; i_req_addr = addr; i_req_len = len; i_req_size = size;
    end
  endtask

  task automatic dropRequests();
    i_req_valid = 0;
    d_req_valid = 0;
    d_req_write = 0;
  endtask

  function automatic logic [DW-1:0] beatData(input logic [AW-1:0] addr, input int b);
    return 64'hDA7A_0000_0000_0000 ^ addr ^ 64'(b * 17);
  endfunction

  initial begin
    rdVec_t t;
    logic [3:0] arbExpD;
`ifdef AXI_ARB_RR_EN
    arbExpD = 4'b1010;
`else
    arbExpD = 4'b1111;
`endif
    vecs[0] = '{owner:1'b0, addr:64'h8000_0000, len:8'd3, size:3'd3, rresp:2'b00, expArid:4'd0, expResp:2'b00};
    vecs[1] = '{owner:1'b1, addr:64'h8000_1000, len:8'd2, size:3'd3, rresp:2'b10, expArid:4'd1, expResp:2'b10};
    vecs[2] = '{owner:1'b1, addr:64'h8000_2040, len:8'd0, size:3'd2, rresp:2'b00, expArid:4'd1, expResp:2'b00};
    vecs[3] = '{owner:1'b0, addr:64'h8000_0100, len:8'd1, size:3'd3, rresp:2'b11, expArid:4'd0, expResp:2'b11};

    clearInputs();
    reset = 1;
    tick();
    tick();
    #1;
    checkOutput("rst_i_req_ready", i_req_ready, 0);
    checkOutput("rst_d_req_ready", d_req_ready, 0);
    checkOutput("rst_arvalid", arvalid, 0);
    checkOutput("rst_awvalid", awvalid, 0);
    checkOutput("rst_rready", rready, 0);
    checkOutput("rst_bready", bready, 0);
    checkOutput("rst_wlast", wlast, 0);
    checkOutput("rst_arburst", arburst, 0);
    checkOutput("rst_arcache", arcache, 0);
    reset = 0;
    tick();

    // Table-driven read bursts, issued back to back
    for (int v = 0; v < 4; v++) begin
      t = vecs[v];
      applyStimulus(t.owner, t.addr, t.len, t.size);
      #1;
      checkOutput("rd_grant", t.owner ? d_req_ready : i_req_ready, 1);
      checkOutput("rd_other_ready", t.owner ? i_req_ready : d_req_ready, 0);
      tick();
      dropRequests();
      #1;
      checkOutput("arvalid", arvalid, 1);
      checkOutput("araddr", araddr, t.addr);
      checkOutput("arlen", arlen, t.len);
      checkOutput("arsize", arsize, t.size);
      checkOutput("arburst", arburst, 2'b01);
      checkOutput("arcache", arcache, 4'b0010);
      checkOutput("arid", arid, t.expArid);
      checkOutput("ar_ready_idle", i_req_ready | d_req_ready, 0);
      arready = 1;
      tick();
      arready = 0;
      #1;
      checkOutput("arvalid_clr", arvalid, 0);
      checkOutput("rready", rready, 1);
      for (int b = 0; b <= int'(t.len); b++) begin
        rvalid = 1;
        rdata  = beatData(t.addr, b);
        rresp  = t.rresp;
        rlast  = (b == int'(t.len));
        #1;
        checkOutput("r_valid", t.owner ? d_r_valid : i_r_valid, 1);
        checkOutput("r_valid_other", t.owner ? i_r_valid : d_r_valid, 0);
        checkOutput("r_data", t.owner ? d_r_data : i_r_data, beatData(t.addr, b));
        checkOutput("r_resp", t.owner ? d_r_resp : i_r_resp, t.expResp);
        checkOutput("r_last", t.owner ? d_r_last : i_r_last, (b == int'(t.len)) ? 1 : 0);
        tick();
      end
      rvalid = 0;
      rlast  = 0;
      rresp  = '0;
    end

    // dbus write, len=1, both W beats before awready
    d_req_write = 1; d_req_addr = 64'h8000_8000; d_req_len = 8'd1; d_req_size = 3'd3;
    d_req_valid = 1;
    d_w_valid = 1; d_w_data = 64'h1111_2222_3333_4444; d_w_strb = 8'hFF;
    #1;
    checkOutput("wrA_grant", d_req_ready, 1);
    checkOutput("wrA_wvalid_idle", wvalid, 0);
    tick();
    dropRequests();
    wready = 1;
    #1;
    checkOutput("wrA_awvalid", awvalid, 1);
    checkOutput("wrA_awaddr", awaddr, 64'h8000_8000);
    checkOutput("wrA_awlen", awlen, 1);
    checkOutput("wrA_awid", awid, 1);
    checkOutput("wrA_awburst", awburst, 2'b01);
    checkOutput("wrA_wvalid0", wvalid, 1);
    checkOutput("wrA_dwready0", d_w_ready, 1);
    checkOutput("wrA_wlast0", wlast, 0);
    checkOutput("wrA_wdata0", wdata, 64'h1111_2222_3333_4444);
    checkOutput("wrA_wstrb0", wstrb, 8'hFF);
    tick();
    d_w_data = 64'h5555_6666_7777_8888;
    #1;
    checkOutput("wrA_awvalid_held", awvalid, 1);
    checkOutput("wrA_wlast1", wlast, 1);
    checkOutput("wrA_wdata1", wdata, 64'h5555_6666_7777_8888);
    tick();
    awready = 1;
    #1;
    checkOutput("wrA_wvalid_done", wvalid, 0);
    checkOutput("wrA_dwready_done", d_w_ready, 0);
    checkOutput("wrA_bready_early", bready, 0);
    tick();
    awready = 0; d_w_valid = 0; wready = 0;
    #1;
    checkOutput("wrA_awvalid_clr", awvalid, 0);
    checkOutput("wrA_bready", bready, 1);
    checkOutput("wrA_bvalid_early", d_b_valid, 0);
    bvalid = 1; bresp = 2'b00;
    #1;
    checkOutput("wrA_d_b_valid", d_b_valid, 1);
    checkOutput("wrA_d_b_resp", d_b_resp, 0);
    tick();
    bvalid = 0;
    #1;
    checkOutput("wrA_d_b_pulse", d_b_valid, 0);
    checkOutput("wrA_bready_clr", bready, 0);

    // dbus write, len=0, awready and the only W beat in the same cycle
    d_req_write = 1; d_req_addr = 64'h8000_9000; d_req_len = 8'd0; d_req_size = 3'd2;
    d_req_valid = 1;
    #1;
    checkOutput("wrB_grant", d_req_ready, 1);
    tick();
    dropRequests();
    d_w_valid = 1; d_w_data = 64'hCAFE_F00D_0000_0001; d_w_strb = 8'h0F;
    wready = 1; awready = 1;
    #1;
    checkOutput("wrB_wlast", wlast, 1);
    checkOutput("wrB_wvalid", wvalid, 1);
    checkOutput("wrB_wstrb", wstrb, 8'h0F);
    checkOutput("wrB_awsize", awsize, 3'd2);
    tick();
    d_w_valid = 0; wready = 0; awready = 0;
    #1;
    checkOutput("wrB_bready", bready, 1);
    checkOutput("wrB_awvalid_clr", awvalid, 0);
    bvalid = 1; bresp = 2'b10;
    #1;
    checkOutput("wrB_d_b_valid", d_b_valid, 1);
    checkOutput("wrB_d_b_resp", d_b_resp, 2'b10);
    tick();
    bvalid = 0; bresp = 2'b00;
    #1;
    checkOutput("wrB_bready_clr", bready, 0);

    // Reset during beat 2 of a len=7 ibus read
    applyStimulus(1'b0, 64'h8000_4000, 8'd7, 3'd3);
    #1;
    checkOutput("rst_rd_grant", i_req_ready, 1);
    tick();
    dropRequests();
    arready = 1;
    tick();
    arready = 0;
    rvalid = 1; rdata = beatData(64'h8000_4000, 0); rlast = 0;
    tick();
    rdata = beatData(64'h8000_4000, 1);
    reset = 1;
    tick();
    reset = 0; rvalid = 0;
    #1;
    checkOutput("mid_rst_rready", rready, 0);
    checkOutput("mid_rst_arvalid", arvalid, 0);
    checkOutput("mid_rst_i_r_valid", i_r_valid, 0);
    checkOutput("mid_rst_i_r_data", i_r_data, 0);
    checkOutput("mid_rst_awvalid", awvalid, 0);
    checkOutput("mid_rst_bready", bready, 0);
    checkOutput("mid_rst_arlen", arlen, 0);
    applyStimulus(1'b0, 64'h8000_5000, 8'd0, 3'd3);
    #1;
    checkOutput("post_rst_grant", i_req_ready, 1);
    tick();
    dropRequests();
    #1;
    checkOutput("post_rst_araddr", araddr, 64'h8000_5000);
    arready = 1;
    tick();
    arready = 0;
    rvalid = 1; rlast = 1; rdata = 64'h0123_4567_89AB_CDEF;
    #1;
    checkOutput("post_rst_i_r_last", i_r_last, 1);
    tick();
    rvalid = 0; rlast = 0;

    // Arbitration: both requesters in the same cycle, four times, from a fresh reset
    reset = 1;
    tick();
    tick();
    reset = 0;
    tick();
    for (int r = 0; r < 4; r++) begin
      applyStimulus(1'b0, 64'h8000_A000, 8'd0, 3'd3);
      applyStimulus(1'b1, 64'h8000_B000, 8'd0, 3'd3);
      #1;
      checkOutput("arb_d_ready", d_req_ready, arbExpD[r]);
      checkOutput("arb_i_ready", i_req_ready, !arbExpD[r]);
      tick();
      dropRequests();
      #1;
      checkOutput("arb_arid", arid, {3'b000, arbExpD[r]});
      arready = 1;
      tick();
      arready = 0;
      rvalid = 1; rlast = 1; rdata = 64'(r);
      #1;
      checkOutput("arb_r_valid", arbExpD[r] ? d_r_valid : i_r_valid, 1);
      tick();
      rvalid = 0; rlast = 0;
    end

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
